// File: rtl/aqp_uart_tx_fifo_if.sv
// Host-side bus for aqp_uart_tx_fifo.
//   master : host (drives tx_data/tx_valid; sees ready, busy, level, overflow)
//   slave  : transmitter
// Signals:
//   tx_data     [DATA_BITS]  word to enqueue
//   tx_valid                 write strobe, one push per cycle while high
//   tx_ready                 FIFO not full
//   tx_busy                  FIFO non-empty or frame in progress
//   fifo_level  [FIFO_AW+1]  FIFO occupancy 0..2**FIFO_AW
//   tx_overflow              one-cycle pulse after a dropped write
interface aqp_uart_tx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 4
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic [FIFO_AW:0]     fifo_level;
    logic                 tx_overflow;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, fifo_level, tx_overflow
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, fifo_level, tx_overflow
    );
endinterface

// File: rtl/aqp_uart_tx_fifo.sv
// UART transmitter with input FIFO, programmable frame format and CTS flow
// control. Frames go out back-to-back while CTS allows; bit timing restarts
// at every frame.
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   uart_txd    serial line, registered, idle high
//   uart_cts_n  clear-to-send, active low, asynchronous (2-flop synchronised)
//   host        aqp_uart_tx_fifo_if.slave: tx_data, tx_valid, tx_ready,
//               tx_busy, fifo_level, tx_overflow
module aqp_uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_AW      = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic                uart_txd,
    input  logic                uart_cts_n,
    aqp_uart_tx_fifo_if.slave   host
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int TW    = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]    TICK_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [FIFO_AW:0] FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (PARITY != 0 && PARITY != 1 && PARITY != 2) ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_AW < 1) begin : g_bad_param
        $error("aqp_uart_tx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic                 r_cts_meta, r_cts_sync;
    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wptr, r_rptr;
    logic [FIFO_AW:0]     r_count;
    logic                 r_overflow;

    state_t               r_state, w_state_nxt;
    logic [TW-1:0]        r_tick, w_tick_nxt;
    logic [3:0]           r_bitcnt, w_bitcnt_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_par, w_par_nxt;
    logic                 r_line, w_line_nxt;

    logic                 w_push, w_pop, w_empty, w_can_start, w_tick_last;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

    assign w_empty          = (r_count == '0);
    assign host.tx_ready    = (r_count != FULL_LEVEL);
    assign w_push           = host.tx_valid && host.tx_ready;
    assign host.fifo_level  = r_count;
    assign host.tx_overflow = r_overflow;
    assign host.tx_busy     = !w_empty || (r_state != S_IDLE);
    // CTS is only consulted here, i.e. at frame boundaries.
    assign w_can_start      = !w_empty && !r_cts_sync;
    assign w_tick_last      = (r_tick == TICK_LAST);
    assign w_head           = r_mem[r_rptr];
    assign w_head_par       = (PARITY == 1) ? ~^w_head : ^w_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
        end else begin
            r_cts_meta <= uart_cts_n;
            r_cts_sync <= r_cts_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= host.tx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow <= host.tx_valid && !host.tx_ready;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = w_tick_last ? '0 : r_tick + 1'b1;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_par_nxt    = r_par;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tick_nxt = '0;
                if (w_can_start) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_head;
                    w_par_nxt    = w_head_par;
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = S_START;
                end
            end
            S_START: begin
                if (w_tick_last) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_tick_last) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bitcnt == DATA_LAST) begin
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick_last) begin
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick_last) begin
                    if (r_bitcnt == STOP_LAST) begin
                        // Last stop cycle doubles as the next frame's launch point.
                        if (w_can_start) begin
                            w_pop        = 1'b1;
                            w_shift_nxt  = w_head;
                            w_par_nxt    = w_head_par;
                            w_bitcnt_nxt = '0;
                            w_tick_nxt   = '0;
                            w_state_nxt  = S_START;
                        end else begin
                            w_state_nxt  = S_IDLE;
                        end
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // The line register follows the next state so uart_txd lags it by one flop.
        case (w_state_nxt)
            S_START:  w_line_nxt = 1'b0;
            S_DATA:   w_line_nxt = w_shift_nxt[0];
            S_PARITY: w_line_nxt = w_par_nxt;
            default:  w_line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_tick   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_line   <= 1'b1;
            uart_txd <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_tick   <= w_tick_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_par    <= w_par_nxt;
            r_line   <= w_line_nxt;
            uart_txd <= r_line;
        end
    end
endmodule

// File: tb/tb_aqp_uart_tx_fifo.sv
// Self-checking bench for aqp_uart_tx_fifo: an 8N1 instance plus 7E2 and 7O2
// instances. A line decoder rebuilds frames from uart_txd; expected data,
// parity and timing come from plain arithmetic on the frame format.
module tb_aqp_uart_tx_fifo;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic reset;
    logic txd0, txd1, txd2;
    logic cts0, cts12;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   nstart [3] = '{0, 0, 0};

    typedef struct {
        logic [8:0] data;
        logic       par;
        bit         ok;
        int         t;
    } frame_t;

    frame_t rx0[$], rx1[$], rx2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aqp_uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_AW(4)) h0 ();
    aqp_uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_AW(2)) h1 ();
    aqp_uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_AW(2)) h2 ();

    aqp_uart_tx_fifo dut0 (
        .clk(clk), .reset(reset), .uart_txd(txd0), .uart_cts_n(cts0), .host(h0)
    );
    aqp_uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_AW(2)) dut1 (
        .clk(clk), .reset(reset), .uart_txd(txd1), .uart_cts_n(cts12), .host(h1)
    );
    aqp_uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_AW(2)) dut2 (
        .clk(clk), .reset(reset), .uart_txd(txd2), .uart_cts_n(cts12), .host(h2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic line_of(input int d);
        case (d)
            0:       return txd0;
            1:       return txd1;
            default: return txd2;
        endcase
    endfunction

    function automatic int rx_size(input int d);
        case (d)
            0:       return rx0.size();
            1:       return rx1.size();
            default: return rx2.size();
        endcase
    endfunction

    // Parity bit that makes data+parity odd (mode 1) or even (mode 2).
    function automatic logic ref_par(input int v, input int dbits, input int mode);
        int ones = 0;
        for (int i = 0; i < dbits; i++) ones += (v >> i) & 1;
        if (mode == 2) return (ones % 2) == 1;
        return (ones % 2) == 0;
    endfunction

    // Decodes frames on one line: every bit must hold for exactly CPB samples.
    task automatic monitor(input int d, input int dbits, input int par, input int stops);
        int         nb;
        int         t;
        logic [15:0] bits;
        logic       s;
        bit         ok, aborted;
        frame_t     f;
        nb = 1 + dbits + ((par != 0) ? 1 : 0) + stops;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0 || line_of(d) !== 1'b0) continue;
            nstart[d]++;
            t = cyc; ok = 1'b1; aborted = 1'b0; bits = '0;
            for (int b = 0; b < nb; b++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (reset !== 1'b0) aborted = 1'b1;
                    s = line_of(d);
                    if (c == 0) bits[b] = s;
                    else if (s !== bits[b]) ok = 1'b0;
                end
            end
            if (!aborted) begin
                f.data = '0;
                for (int i = 0; i < dbits; i++) f.data[i] = bits[1+i];
                f.par = (par != 0) ? bits[1+dbits] : 1'b0;
                if (bits[0] !== 1'b0) ok = 1'b0;
                for (int i = 0; i < stops; i++) if (bits[nb-1-i] !== 1'b1) ok = 1'b0;
                f.ok = ok;
                f.t  = t;
                case (d)
                    0:       rx0.push_back(f);
                    1:       rx1.push_back(f);
                    default: rx2.push_back(f);
                endcase
            end
        end
    endtask

    initial monitor(0, 8, 0, 1);
    initial monitor(1, 7, 2, 2);
    initial monitor(2, 7, 1, 2);

    task automatic put(input int d, input int v);
        case (d)
            0:       begin h0.tx_data = 8'(v); h0.tx_valid = 1'b1; end
            1:       begin h1.tx_data = 7'(v); h1.tx_valid = 1'b1; end
            default: begin h2.tx_data = 7'(v); h2.tx_valid = 1'b1; end
        endcase
        @(posedge clk); #1;
        h0.tx_valid = 1'b0; h1.tx_valid = 1'b0; h2.tx_valid = 1'b0;
    endtask

    task automatic expect_frame(input int d, input int exp_data, input int exp_par,
                                input string tag, output int t);
        frame_t f;
        bit     got = 1'b0;
        t = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            if (rx_size(d) > 0) begin
                case (d)
                    0:       f = rx0.pop_front();
                    1:       f = rx1.pop_front();
                    default: f = rx2.pop_front();
                endcase
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_arrive"}, int'(got), 1);
        if (got) begin
            check({tag, "_data"}, int'(f.data), exp_data);
            check({tag, "_shape"}, int'(f.ok), 1);
            if (exp_par >= 0) check({tag, "_par"}, int'(f.par), exp_par);
            t = f.t;
        end
    endtask

    task automatic wait_starts(input int d, input int target, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            if (nstart[d] >= target) hit = 1'b1;
            else @(negedge clk);
        end
        check(tag, int'(hit), 1);
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got no completion, expected finish before 1ms");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tn, t, tp, m, base;
        int v1 [4];
        int v2 [4];
        int exp0 [$];

        reset = 1'b1; cts0 = 1'b1; cts12 = 1'b0;
        h0.tx_valid = 1'b0; h1.tx_valid = 1'b0; h2.tx_valid = 1'b0;
        h0.tx_data = '0; h1.tx_data = '0; h2.tx_data = '0;
        #23;
        check("rst_txd", int'(txd0), 1);
        check("rst_level", int'(h0.fifo_level), 0);
        check("rst_ready", int'(h0.tx_ready), 1);
        check("rst_busy", int'(h0.tx_busy), 0);
        check("rst_ovf", int'(h0.tx_overflow), 0);
        reset = 1'b0;
        cts0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 8N1 single frame: latency, bit order, busy window.
        put(0, 8'h55);
        tn = cyc;
        check("s1_level_push", int'(h0.fifo_level), 1);
        check("s1_busy_push", int'(h0.tx_busy), 1);
        @(posedge clk); #1;
        check("s1_txd_n1", int'(txd0), 1);
        check("s1_level_pop", int'(h0.fifo_level), 0);
        @(posedge clk); #1;
        check("s1_txd_n2", int'(txd0), 0);
        repeat (78) @(posedge clk);
        #1;
        check("s1_busy_n80", int'(h0.tx_busy), 1);
        @(posedge clk); #1;
        check("s1_busy_n81", int'(h0.tx_busy), 0);
        expect_frame(0, 8'h55, -1, "s1", t);
        check("s1_latency", t - tn, 2);

        // 7E2 and 7O2: fixed 0x07 then random words, 88-cycle frames.
        v1[0] = 7; v2[0] = 7;
        for (int k = 1; k < 4; k++) begin
            v1[k] = int'($urandom_range(0, 127));
            v2[k] = int'($urandom_range(0, 127));
        end
        for (int k = 0; k < 4; k++) put(1, v1[k]);
        for (int k = 0; k < 4; k++) put(2, v2[k]);
        expect_frame(1, 7, 1, "s2_even_fixed", tp);
        for (int k = 1; k < 4; k++) begin
            expect_frame(1, v1[k], int'(ref_par(v1[k], 7, 2)), "s2_even_rand", t);
            check("s2_even_gap", t - tp, 88);
            tp = t;
        end
        expect_frame(2, 7, 0, "s2_odd_fixed", tp);
        for (int k = 1; k < 4; k++) begin
            expect_frame(2, v2[k], int'(ref_par(v2[k], 7, 1)), "s2_odd_rand", t);
            check("s2_odd_gap", t - tp, 88);
            tp = t;
        end

        // CTS held off: 17 writes on consecutive cycles, the last one dropped.
        @(posedge clk); #1;
        cts0 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        base = nstart[0];
        for (int k = 0; k < 17; k++) begin
            int v;
            v = int'($urandom_range(0, 255));
            if (k < 16) exp0.push_back(v);
            put(0, v);
            check("s3_level", int'(h0.fifo_level), (k < 16) ? k + 1 : 16);
            check("s3_ovf", int'(h0.tx_overflow), (k == 16) ? 1 : 0);
        end
        check("s3_ready_full", int'(h0.tx_ready), 0);
        @(posedge clk); #1;
        check("s3_ovf_clear", int'(h0.tx_overflow), 0);
        repeat (20) @(posedge clk);
        #1;
        check("s3_txd_idle", int'(txd0), 1);
        check("s3_no_frames", nstart[0] - base, 0);

        // Release CTS: 16 back-to-back frames in write order.
        cts0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("s4_level_first_pop", int'(h0.fifo_level), 15);
        tp = 0;
        for (int k = 0; k < 16; k++) begin
            expect_frame(0, exp0.pop_front(), -1, "s4", t);
            if (k > 0) check("s4_gap", t - tp, 80);
            tp = t;
        end
        repeat (3) @(posedge clk);
        #1;
        check("s4_busy_end", int'(h0.tx_busy), 0);
        check("s4_level_end", int'(h0.fifo_level), 0);

        // CTS raised during frame 3: frame completes, rest stays queued.
        base = nstart[0];
        for (int k = 0; k < 6; k++) begin
            int v;
            v = int'($urandom_range(0, 255));
            exp0.push_back(v);
            put(0, v);
        end
        wait_starts(0, base + 3, "s5_reach_f3");
        repeat (40) @(negedge clk);
        cts0 = 1'b1;
        tp = 0;
        for (int k = 0; k < 3; k++) begin
            expect_frame(0, exp0.pop_front(), -1, "s5_pre", t);
            if (k > 0) check("s5_pre_gap", t - tp, 80);
            tp = t;
        end
        repeat (200) @(posedge clk);
        #1;
        check("s5_held_frames", nstart[0] - base, 3);
        check("s5_held_level", int'(h0.fifo_level), 3);
        check("s5_held_txd", int'(txd0), 1);
        check("s5_held_busy", int'(h0.tx_busy), 1);
        m = cyc;
        cts0 = 1'b0;
        expect_frame(0, exp0.pop_front(), -1, "s5_resume", t);
        check("s5_resume_within", int'((t - m) <= 5), 1);
        for (int k = 0; k < 2; k++) begin
            tp = t;
            expect_frame(0, exp0.pop_front(), -1, "s5_post", t);
            check("s5_post_gap", t - tp, 80);
        end

        // Reset during a data bit: line high at once, queue flushed, no resume.
        base = nstart[0];
        for (int k = 0; k < 3; k++) put(0, int'($urandom_range(0, 255)));
        wait_starts(0, base + 1, "s6_started");
        repeat (20) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("s6_txd_reset", int'(txd0), 1);
        check("s6_level_reset", int'(h0.fifo_level), 0);
        check("s6_busy_reset", int'(h0.tx_busy), 0);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        base = nstart[0];
        repeat (150) @(posedge clk);
        #1;
        check("s6_no_resume", nstart[0] - base, 0);
        check("s6_no_partial", rx_size(0), 0);
        check("s6_txd_idle", int'(txd0), 1);
        begin
            int v;
            v = int'($urandom_range(0, 255));
            put(0, v);
            expect_frame(0, v, -1, "s6_fresh", t);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
